// File: rtl/imsic_pkg.sv
// Shared definitions for the IMSIC MSI delivery slice: info-word layout,
// arbiter FSM encoding and counter width.
package imsic_pkg;

   // MSI info word is {hart, file, src}
   localparam int SRC_W  = 11;
   localparam int FILE_W = 1;
   localparam int HART_W = 5;
   localparam int INFO_W = HART_W + FILE_W + SRC_W;

   localparam int SRC_LSB  = 0;
   localparam int FILE_LSB = SRC_LSB + SRC_W;
   localparam int HART_LSB = FILE_LSB + FILE_W;

   localparam int CNT_W = 4;

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] HOLD = 2'd1;
   localparam logic [1:0] GAP  = 2'd2;

endpackage

// File: rtl/imsic_rr_arb.sv
// Rotating-priority picker: first set request at or above i_ptr, wrapping.
// Purely combinational; o_gnt is one-hot (zero when nothing requests).
module imsic_rr_arb #(
   parameter int NR_REQ = 4,
   parameter int IDX_W  = $clog2(NR_REQ)
) (
   input  logic [NR_REQ-1:0] i_req,
   input  logic [IDX_W-1:0]  i_ptr,
   output logic [NR_REQ-1:0] o_gnt,
   output logic [IDX_W-1:0]  o_idx
);

   logic [2*NR_REQ-1:0] w_dbl;
   logic [NR_REQ-1:0]   w_rot;
   logic [IDX_W-1:0]    w_off;
   logic [IDX_W:0]      w_sum;
   logic [IDX_W:0]      w_wrap;

   // Rotate so i_ptr lands on bit 0, pick the lowest offset, rotate back
   always_comb begin
      w_dbl = {i_req, i_req} >> i_ptr;
      w_rot = w_dbl[NR_REQ-1:0];
      w_off = {IDX_W{1'b0}};
      for (int k = NR_REQ - 1; k >= 0; k--) begin
         w_off = w_rot[k] ? IDX_W'(k) : w_off;
      end
      w_sum  = {1'b0, i_ptr} + {1'b0, w_off};
      w_wrap = (w_sum >= (IDX_W+1)'(NR_REQ)) ? (w_sum - (IDX_W+1)'(NR_REQ)) : w_sum;
      o_idx  = w_wrap[IDX_W-1:0];
      o_gnt  = (|i_req) ? (NR_REQ'(1) << o_idx) : {NR_REQ{1'b0}};
   end

endmodule

// File: rtl/imsic_msi_arbiter.sv
// Shares the single MSI-info delivery channel among NR_REQ requesters:
// round-robin grant, one message in flight, fixed vld hold window plus guard gap.
module imsic_msi_arbiter
   import imsic_pkg::*;
#(
   parameter int NR_REQ      = 4,
   parameter int INFO_WIDTH  = INFO_W,
   parameter int KEEP_CYCLES = 8,
   parameter int GAP_CYCLES  = 2
) (
   input  logic                         clk,
   input  logic                         rstn,
   input  logic [NR_REQ-1:0]            req_vld,
   input  logic [NR_REQ*INFO_WIDTH-1:0] req_info,
   output logic [NR_REQ-1:0]            req_rdy,
   output logic [INFO_WIDTH-1:0]        o_msi_info,
   output logic                         o_msi_info_vld,
   output logic [$clog2(NR_REQ)-1:0]    o_grant_id,
   output logic                         o_busy
);

   localparam int IDX_W = $clog2(NR_REQ);
   localparam logic [CNT_W-1:0] KEEP_LAST = CNT_W'(KEEP_CYCLES - 1);
   localparam logic [CNT_W-1:0] GAP_LAST  = (GAP_CYCLES == 0) ? {CNT_W{1'b0}} : CNT_W'(GAP_CYCLES - 1);

   if (NR_REQ < 2 || KEEP_CYCLES < 2 || KEEP_CYCLES > 15 || GAP_CYCLES < 0 || GAP_CYCLES > 15) begin : g_param_err
      $error("imsic_msi_arbiter: NR_REQ/KEEP_CYCLES/GAP_CYCLES out of range");
   end

   logic [1:0]            r_state;
   logic [CNT_W-1:0]      r_cnt;
   logic [IDX_W-1:0]      r_ptr;
   logic [INFO_WIDTH-1:0] r_info;
   logic                  r_vld;
   logic [IDX_W-1:0]      r_gid;
   logic                  r_busy;

   logic [NR_REQ-1:0]     w_gnt;
   logic [IDX_W-1:0]      w_idx;
   logic [INFO_WIDTH-1:0] w_info;
   logic                  w_accept;
   logic [IDX_W-1:0]      w_ptr_nxt;

   imsic_rr_arb #(
      .NR_REQ (NR_REQ),
      .IDX_W  (IDX_W)
   ) u_rr_arb (
      .i_req (req_vld),
      .i_ptr (r_ptr),
      .o_gnt (w_gnt),
      .o_idx (w_idx)
   );

   assign w_accept  = (r_state == IDLE) && (|req_vld);
   assign w_info    = req_info[int'(w_idx)*INFO_WIDTH +: INFO_WIDTH];
   assign w_ptr_nxt = (w_idx == IDX_W'(NR_REQ - 1)) ? {IDX_W{1'b0}} : (w_idx + IDX_W'(1));

   // Ready is forced low while reset is held so nothing is accepted into a dead FSM
   assign req_rdy = (w_accept && rstn) ? w_gnt : {NR_REQ{1'b0}};

   // Delivery FSM: IDLE grants, HOLD drives vld for KEEP_CYCLES, GAP keeps vld low
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_state <= IDLE;
         r_cnt   <= {CNT_W{1'b0}};
         r_ptr   <= {IDX_W{1'b0}};
         r_info  <= {INFO_WIDTH{1'b0}};
         r_vld   <= 1'b0;
         r_gid   <= {IDX_W{1'b0}};
         r_busy  <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_accept) begin
                  r_info  <= w_info;
                  r_gid   <= w_idx;
                  r_ptr   <= w_ptr_nxt;
                  r_cnt   <= {CNT_W{1'b0}};
                  r_vld   <= 1'b1;
                  r_busy  <= 1'b1;
                  r_state <= HOLD;
               end
            end
            HOLD: begin
               if (r_cnt == KEEP_LAST) begin
                  r_cnt <= {CNT_W{1'b0}};
                  r_vld <= 1'b0;
                  if (GAP_CYCLES == 0) begin
                     r_state <= IDLE;
                     r_busy  <= 1'b0;
                  end else begin
                     r_state <= GAP;
                  end
               end else begin
                  r_cnt <= r_cnt + CNT_W'(1);
               end
            end
            GAP: begin
               if (r_cnt == GAP_LAST) begin
                  r_cnt   <= {CNT_W{1'b0}};
                  r_state <= IDLE;
                  r_busy  <= 1'b0;
               end else begin
                  r_cnt <= r_cnt + CNT_W'(1);
               end
            end
            default: begin
               r_state <= IDLE;
               r_cnt   <= {CNT_W{1'b0}};
               r_vld   <= 1'b0;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign o_msi_info     = r_info;
   assign o_msi_info_vld = r_vld;
   assign o_grant_id     = r_gid;
   assign o_busy         = r_busy;

endmodule

// File: tb/tb_imsic_msi_arbiter.sv
// Directed bench for imsic_msi_arbiter: one default instance (GAP=2) and one GAP=0 instance.
module tb_imsic_msi_arbiter;

   logic        clk;
   logic        rstn;
   logic [3:0]  req_vld_a, req_vld_b;
   logic [67:0] req_info;
   logic [3:0]  rdy_a, rdy_b;
   logic [16:0] info_a, info_b;
   logic        vld_a, vld_b;
   logic [1:0]  gid_a, gid_b;
   logic        busy_a, busy_b;

   logic        sel;
   logic [3:0]  o_rdy;
   logic [16:0] o_info;
   logic        o_vld;
   logic [1:0]  o_gid;
   logic        o_busy;

   int n_checks;
   int n_errors;
   int n;
   int hi;
   logic [16:0] tinfo [4];

   imsic_msi_arbiter u_dut_a (
      .clk(clk), .rstn(rstn), .req_vld(req_vld_a), .req_info(req_info), .req_rdy(rdy_a),
      .o_msi_info(info_a), .o_msi_info_vld(vld_a), .o_grant_id(gid_a), .o_busy(busy_a)
   );

   imsic_msi_arbiter #(.GAP_CYCLES(0)) u_dut_b (
      .clk(clk), .rstn(rstn), .req_vld(req_vld_b), .req_info(req_info), .req_rdy(rdy_b),
      .o_msi_info(info_b), .o_msi_info_vld(vld_b), .o_grant_id(gid_b), .o_busy(busy_b)
   );

   assign o_rdy  = sel ? rdy_b  : rdy_a;
   assign o_info = sel ? info_b : info_a;
   assign o_vld  = sel ? vld_b  : vld_a;
   assign o_gid  = sel ? gid_b  : gid_a;
   assign o_busy = sel ? busy_b : busy_a;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // step to the falling edge of the next cycle
   task automatic cyc();
      @(posedge clk);
      #5;
   endtask

   task automatic wait_accept(output int cnt);
      cnt = 0;
      while (o_rdy == 4'd0 && cnt < 40) begin
         cyc();
         cnt++;
      end
      chk("accept_timeout", {31'd0, o_rdy != 4'd0}, 32'd1);
   endtask

   // counts vld-high cycles from the current one, stops on the first low cycle
   task automatic burst(output int cnt);
      cnt = 0;
      while (o_vld && cnt < 20) begin
         cnt++;
         cyc();
      end
   endtask

   task automatic wait_idle();
      int k;
      k = 0;
      while (o_busy && k < 40) begin
         cyc();
         k++;
      end
      chk("idle_timeout", {31'd0, o_busy}, 32'd0);
   endtask

   initial begin
      n_checks  = 0;
      n_errors  = 0;
      sel       = 1'b0;
      rstn      = 1'b0;
      req_vld_a = 4'd0;
      req_vld_b = 4'd0;
      tinfo[0]  = 17'h01111;
      tinfo[1]  = 17'h0A5A3;
      tinfo[2]  = 17'h12222;
      tinfo[3]  = 17'h1C3C3;
      req_info  = {tinfo[3], tinfo[2], tinfo[1], tinfo[0]};
      cyc();
      cyc();

      // reset state
      chk("rst_info", {15'd0, o_info}, 32'd0);
      chk("rst_vld", {31'd0, o_vld}, 32'd0);
      chk("rst_gid", {30'd0, o_gid}, 32'd0);
      chk("rst_busy", {31'd0, o_busy}, 32'd0);
      chk("rst_rdy", {28'd0, o_rdy}, 32'd0);
      rstn = 1'b1;
      cyc();

      // 1: single request from requester 1
      req_vld_a = 4'b0010;
      #1;
      chk("t1_rdy", {28'd0, o_rdy}, 32'h2);
      cyc();
      chk("t1_vld", {31'd0, o_vld}, 32'd1);
      chk("t1_info", {15'd0, o_info}, 32'h0A5A3);
      chk("t1_gid", {30'd0, o_gid}, 32'd1);
      chk("t1_busy", {31'd0, o_busy}, 32'd1);
      chk("t1_rdy_hold", {28'd0, o_rdy}, 32'd0);
      burst(hi);
      chk("t1_burst", hi, 32'd8);
      wait_accept(n);
      chk("t1_next_rdy_dist", n, 32'd2);
      req_vld_a = 4'd0;
      cyc();
      wait_idle();
      rstn = 1'b0;
      cyc();
      rstn = 1'b1;
      cyc();

      // 2: all four requesting, order 0,1,2,3,0
      req_vld_a = 4'hF;
      #1;
      for (int g = 0; g < 5; g++) begin
         wait_accept(n);
         if (g > 0) chk("t2_gap", n, 32'd2);
         chk("t2_rdy", {28'd0, o_rdy}, 32'd1 << (g % 4));
         cyc();
         chk("t2_gid", {30'd0, o_gid}, g % 4);
         chk("t2_info", {15'd0, o_info}, {15'd0, tinfo[g % 4]});
         burst(hi);
         chk("t2_burst", hi, 32'd8);
      end
      req_vld_a = 4'd0;
      wait_idle();

      // 3: requester 3 back-to-back, 0 joins mid-HOLD -> 0 then 3
      req_vld_a = 4'b1000;
      #1;
      wait_accept(n);
      chk("t3_rdy3", {28'd0, o_rdy}, 32'h8);
      cyc();
      cyc();
      cyc();
      cyc();
      req_vld_a = 4'b1001;
      burst(hi);
      chk("t3_burst_tail", hi, 32'd5);
      wait_accept(n);
      chk("t3_rdy0", {28'd0, o_rdy}, 32'h1);
      cyc();
      req_vld_a = 4'b1000;
      chk("t3_gid0", {30'd0, o_gid}, 32'd0);
      burst(hi);
      wait_accept(n);
      chk("t3_rdy3b", {28'd0, o_rdy}, 32'h8);
      cyc();
      req_vld_a = 4'd0;
      chk("t3_gid3", {30'd0, o_gid}, 32'd3);
      burst(hi);
      wait_idle();

      // 5: reset in HOLD at cnt=4, then fresh grant for requester 2
      req_vld_a = 4'b0010;
      #1;
      wait_accept(n);
      chk("t5_rdy1", {28'd0, o_rdy}, 32'h2);
      cyc();
      req_vld_a = 4'd0;
      cyc();
      cyc();
      cyc();
      cyc();
      chk("t5_vld_pre", {31'd0, o_vld}, 32'd1);
      rstn = 1'b0;
      req_vld_a = 4'b0100;
      #1;
      chk("t5_vld_rst", {31'd0, o_vld}, 32'd0);
      chk("t5_busy_rst", {31'd0, o_busy}, 32'd0);
      chk("t5_info_rst", {15'd0, o_info}, 32'd0);
      chk("t5_gid_rst", {30'd0, o_gid}, 32'd0);
      chk("t5_rdy_rst", {28'd0, o_rdy}, 32'd0);
      cyc();
      rstn = 1'b1;
      #1;
      chk("t5_rdy2", {28'd0, o_rdy}, 32'h4);
      cyc();
      req_vld_a = 4'd0;
      chk("t5_gid2", {30'd0, o_gid}, 32'd2);
      chk("t5_info2", {15'd0, o_info}, 32'h12222);
      burst(hi);
      chk("t5_burst", hi, 32'd8);

      // 6: request raised in GAP and withdrawn before IDLE
      req_vld_a = 4'b0001;
      cyc();
      chk("t6_rdy_gap", {28'd0, o_rdy}, 32'd0);
      req_vld_a = 4'd0;
      cyc();
      chk("t6_rdy_idle", {28'd0, o_rdy}, 32'd0);
      chk("t6_busy_idle", {31'd0, o_busy}, 32'd0);
      cyc();
      chk("t6_vld", {31'd0, o_vld}, 32'd0);
      chk("t6_gid", {30'd0, o_gid}, 32'd2);
      req_vld_a = 4'b1001;
      #1;
      chk("t6_ptr_kept", {28'd0, o_rdy}, 32'h8);
      cyc();
      req_vld_a = 4'd0;

      // 4: GAP_CYCLES=0 instance, vld low exactly one cycle between bursts
      sel = 1'b1;
      req_vld_b = 4'b0011;
      #1;
      for (int g = 0; g < 3; g++) begin
         wait_accept(n);
         if (g > 0) chk("t4_gap", n, 32'd0);
         chk("t4_rdy", {28'd0, o_rdy}, 32'd1 << (g % 2));
         cyc();
         chk("t4_gid", {30'd0, o_gid}, g % 2);
         burst(hi);
         chk("t4_burst", hi, 32'd8);
      end
      req_vld_b = 4'd0;

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
